nios1_nios2_qsys_mult_unit: RTL

NIOS1_NIOS2_QSYS_MULT_UNIT -- requirements
Module: nios1_nios2_qsys_mult_unit

---
 rtl/nios1_nios2_qsys_mult_pkg.sv | 31 +++
 rtl/nios1_nios2_qsys_mult_unit_pp16.sv | 37 +++
 rtl/nios1_nios2_qsys_mult_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/nios1_nios2_qsys_mult_pkg.sv
// Shared constants for the Nios II multiply unit:
// mode encodings, partial-product width and signedness helpers.
package nios1_nios2_qsys_mult_pkg;

  localparam int PP_W = 16;

  localparam logic [1:0] MODE_MUL    = 2'd0;
  localparam logic [1:0] MODE_MULXSS = 2'd1;
  localparam logic [1:0] MODE_MULXSU = 2'd2;
  localparam logic [1:0] MODE_MULXUU = 2'd3;

  function automatic logic a_signed(
    input logic [1:0] m
  );
    return (m == MODE_MULXSS) ||
           (m == MODE_MULXSU);
  endfunction

  function automatic logic b_signed(
    input logic [1:0] m
  );
    return (m == MODE_MULXSS);
  endfunction

  function automatic logic hi_word(
    input logic [1:0] m
  );
    return (m != MODE_MUL);
  endfunction

endpackage

// File: rtl/nios1_nios2_qsys_mult_unit_pp16.sv
// One unsigned 16x16 partial product, registered unless
// the unit is built as a single merged stage.
module nios1_nios2_qsys_mult_pp16
  import nios1_nios2_qsys_mult_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [PP_W-1:0]   a_i,
  input  logic [PP_W-1:0]   b_i,
  output logic [2*PP_W-1:0] p_o
);

  logic [2*PP_W-1:0] p_d;

  assign p_d = {PP_W'(0), a_i} *
               {PP_W'(0), b_i};

  if (REG_OUT) begin : g_reg
    logic [2*PP_W-1:0] p_q;

    always_ff @(posedge clk_i) begin
      if (en_i) begin
        p_q <= p_d;
      end
    end

    assign p_o = p_q;
  end else begin : g_comb
    logic unused_ctl;

    assign unused_ctl = clk_i ^ en_i;
    assign p_o        = p_d;
  end

endmodule

// File: rtl/nios1_nios2_qsys_mult_unit.sv
// Pipelined MUL/MULX unit: 16x16 partial products, then
// summation with sign correction, then optional delay.
module nios1_nios2_qsys_mult_unit
  import nios1_nios2_qsys_mult_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int NW     = DATA_W / PP_W;
  localparam int NPP    = NW * NW;
  localparam int PW     = 2 * DATA_W;
  localparam bit MERGED = (PIPE_STAGES == 1);
  localparam int RS     = MERGED ? 1
                                 : PIPE_STAGES - 1;

  logic                    stall;
  logic                    en;
  logic [2*PP_W-1:0]       pp_w [NPP];
  logic [1:0]              op_m;
  logic [DATA_W-1:0]       op_a;
  logic [DATA_W-1:0]       op_b;
  logic [PW-1:0]           prod_d;
  logic [DATA_W-1:0]       res_d;
  logic [PIPE_STAGES-1:0]  v_q;
  logic [TAG_W-1:0]        tag_q [PIPE_STAGES];
  logic [DATA_W-1:0]       res_q [RS];

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  for (genvar gi = 0; gi < NW; gi++) begin : g_row
    for (genvar gj = 0; gj < NW; gj++) begin : g_col
      nios1_nios2_qsys_mult_pp16 #(
        .REG_OUT (!MERGED)
      ) u_pp (
        .clk_i (clk),
        .en_i  (en),
        .a_i   (in_src1[gi*PP_W +: PP_W]),
        .b_i   (in_src2[gj*PP_W +: PP_W]),
        .p_o   (pp_w[gi*NW+gj])
      );
    end
  end

  // Mode and operands ride alongside the partial products
  // so the summation stage can apply sign correction.
  if (MERGED) begin : g_s1
    assign op_m = in_mode;
    assign op_a = in_src1;
    assign op_b = in_src2;
  end else begin : g_s1
    logic [1:0]        m_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    always_ff @(posedge clk) begin
      if (en) begin
        m_q <= in_mode;
        a_q <= in_src1;
        b_q <= in_src2;
      end
    end

    assign op_m = m_q;
    assign op_a = a_q;
    assign op_b = b_q;
  end

  // Signed value = unsigned - msb*2^W; the msb*msb term
  // falls outside the 2W-bit product and is dropped.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < NW; i++) begin
      for (int j = 0; j < NW; j++) begin
        prod_d = prod_d +
          (PW'(pp_w[i*NW+j]) << (PP_W*(i+j)));
      end
    end
    if (a_signed(op_m) && op_a[DATA_W-1]) begin
      prod_d = prod_d - (PW'(op_b) << DATA_W);
    end
    if (b_signed(op_m) && op_b[DATA_W-1]) begin
      prod_d = prod_d - (PW'(op_a) << DATA_W);
    end
  end

  assign res_d = hi_word(op_m)
               ? prod_d[PW-1:DATA_W]
               : prod_d[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        tag_q[k] <= '0;
      end
      for (int k = 0; k < RS; k++) begin
        res_q[k] <= '0;
      end
    end else if (en) begin
      v_q[0]   <= in_valid;
      tag_q[0] <= in_tag;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        v_q[k]   <= v_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
      res_q[0] <= res_d;
      for (int k = 1; k < RS; k++) begin
        res_q[k] <= res_q[k-1];
      end
    end
  end

  assign out_valid  = v_q[PIPE_STAGES-1];
  assign out_tag    = tag_q[PIPE_STAGES-1];
  assign out_result = res_q[RS-1];

endmodule
